hazard_ctrl: RTL and testbench

Pipeline hazard and forwarding controller for the 5-stage RISC-V core. Tracks the destination registers of the three instructions ahead of decode (EX, MEM, WB) and drives the values the ID/EX register samples:
- the per-operand forwarding selects;
- the load-use stall;
- the bubble/flush controls for IF/ID and ID/EX, including on a branch mispredict signalled from EX.

It also keeps saturating stall and flush event counters for performance debug.

---
 rtl/hazard_ctrl.sv | 143 ++++++++++++++
 tb/tb_hazard_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard and forwarding controller for the 5-stage core.
// Tracks the destination registers of the EX, MEM and WB instructions and
// derives the forwarding selects, load-use stall and flush controls that the
// IF/ID and ID/EX registers sample. It also keeps saturating event counters.
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_id,
    input  logic [4:0]       RS1_id,
    input  logic [4:0]       RS2_id,
    input  logic             USE1_id,
    input  logic             USE2_id,
    input  logic [4:0]       RD_id,
    input  logic             RW_id,
    input  logic             MD_id,
    input  logic             MP_ex,
    output logic             stall_if,
    output logic             flush_ifid,
    output logic             flush_idex,
    output logic             FW0,
    output logic             FW1,
    output logic             FW00,
    output logic             FW01,
    output logic             FW02,
    output logic             FW10,
    output logic             FW11,
    output logic             FW12,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // History slots for the three instructions ahead of decode
    logic       ex_v, mem_v, wb_v;
    logic [4:0] ex_rd, mem_rd, wb_rd;
    logic       ex_rw, mem_rw, wb_rw;
    logic       ex_md, mem_md, wb_md;

    // Per-source producer matches; bit 0 = EX, bit 1 = MEM, bit 2 = WB
    logic [2:0] match1, match2;
    logic       load_use;
    logic [2:0] sel1, sel2;

    // A slot produces r only if it is valid, writes a register, and r is not x0
    function automatic logic slot_match(input logic v, input logic rw,
                                        input logic [4:0] rd, input logic [4:0] r);
        return v & rw & (rd == r) & (r != 5'd0);
    endfunction

    // Youngest producer wins; the result is one-hot or zero
    function automatic logic [2:0] pick_youngest(input logic [2:0] m);
        logic [2:0] s;
        s = 3'b000;
        if (m[0])      s = 3'b001;
        else if (m[1]) s = 3'b010;
        else if (m[2]) s = 3'b100;
        return s;
    endfunction

    // Producer matches for both source operands against every history slot
    always_comb begin
        match1[0] = slot_match(ex_v,  ex_rw,  ex_rd,  RS1_id);
        match1[1] = slot_match(mem_v, mem_rw, mem_rd, RS1_id);
        match1[2] = slot_match(wb_v,  wb_rw,  wb_rd,  RS1_id);
        match2[0] = slot_match(ex_v,  ex_rw,  ex_rd,  RS2_id);
        match2[1] = slot_match(mem_v, mem_rw, mem_rd, RS2_id);
        match2[2] = slot_match(wb_v,  wb_rw,  wb_rd,  RS2_id);
        load_use  = valid_id & ex_md &
                    ((USE1_id & match1[0]) | (USE2_id & match2[0]));
    end

    // Control decision: reset beats mispredict, mispredict beats load-use
    always_comb begin
        stall_if   = 1'b0;
        flush_ifid = 1'b0;
        flush_idex = 1'b0;
        sel1       = 3'b000;
        sel2       = 3'b000;
        if (reset || MP_ex) begin
            flush_ifid = 1'b1;
            flush_idex = 1'b1;
        end else if (load_use) begin
            stall_if   = 1'b1;
            flush_idex = 1'b1;
        end else begin
            if (valid_id && USE1_id) sel1 = pick_youngest(match1);
            if (valid_id && USE2_id) sel2 = pick_youngest(match2);
        end
    end

    assign FW00 = sel1[0];
    assign FW01 = sel1[1];
    assign FW02 = sel1[2];
    assign FW0  = |sel1;
    assign FW10 = sel2[0];
    assign FW11 = sel2[1];
    assign FW12 = sel2[2];
    assign FW1  = |sel2;

    // Advance the history; a flushed ID/EX enters EX as an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_v  <= 1'b0; ex_rd  <= 5'd0; ex_rw  <= 1'b0; ex_md  <= 1'b0;
            mem_v <= 1'b0; mem_rd <= 5'd0; mem_rw <= 1'b0; mem_md <= 1'b0;
            wb_v  <= 1'b0; wb_rd  <= 5'd0; wb_rw  <= 1'b0; wb_md  <= 1'b0;
        end else begin
            wb_v   <= mem_v;
            wb_rd  <= mem_rd;
            wb_rw  <= mem_rw;
            wb_md  <= mem_md;
            mem_v  <= ex_v;
            mem_rd <= ex_rd;
            mem_rw <= ex_rw;
            mem_md <= ex_md;
            if (flush_idex) begin
                ex_v  <= 1'b0;
                ex_rd <= 5'd0;
                ex_rw <= 1'b0;
                ex_md <= 1'b0;
            end else begin
                ex_v  <= valid_id;
                ex_rd <= RD_id;
                ex_rw <= RW_id;
                ex_md <= MD_id;
            end
        end
    end

    // Saturating performance counters for stall cycles and mispredict flushes
    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_if && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + 1'b1;
            if (MP_ex && flush_cnt != CNT_MAX)    flush_cnt <= flush_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Testbench for hazard_ctrl. A behavioural model predicts every cycle's
// outputs; predictions go into a scoreboard queue when the stimulus is driven
// and are popped and compared at the following falling edge. A second
// instance with 4-bit counters shares the stimulus to exercise saturation.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       valid_id;
    logic [4:0] RS1_id, RS2_id, RD_id;
    logic       USE1_id, USE2_id, RW_id, MD_id, MP_ex;

    logic        stall_if, flush_ifid, flush_idex;
    logic        FW0, FW1, FW00, FW01, FW02, FW10, FW11, FW12;
    logic [15:0] stall_cnt, flush_cnt;

    logic        s_stall_if, s_flush_ifid, s_flush_idex;
    logic        s_FW0, s_FW1, s_FW00, s_FW01, s_FW02, s_FW10, s_FW11, s_FW12;
    logic [3:0]  s_stall_cnt, s_flush_cnt;

    int nVectors = 0;
    int nMiscompares = 0;

    typedef struct packed {
        logic [2:0]  ctl;
        logic [7:0]  fw;
        logic [15:0] sc;
        logic [15:0] fc;
        logic [3:0]  ssc;
        logic [3:0]  sfc;
    } exp_t;

    typedef struct {
        logic       v;
        logic [4:0] rd;
        logic       rw;
        logic       md;
    } slot_t;

    exp_t  sb[$];
    slot_t hist[3];
    int    mStall, mFlush, mStallSat, mFlushSat;

    hazard_ctrl #(.CNT_W(16)) dut (
        .clk(clk), .reset(reset), .valid_id(valid_id),
        .RS1_id(RS1_id), .RS2_id(RS2_id), .USE1_id(USE1_id), .USE2_id(USE2_id),
        .RD_id(RD_id), .RW_id(RW_id), .MD_id(MD_id), .MP_ex(MP_ex),
        .stall_if(stall_if), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
        .FW0(FW0), .FW1(FW1), .FW00(FW00), .FW01(FW01), .FW02(FW02),
        .FW10(FW10), .FW11(FW11), .FW12(FW12),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    hazard_ctrl #(.CNT_W(4)) satDut (
        .clk(clk), .reset(reset), .valid_id(valid_id),
        .RS1_id(RS1_id), .RS2_id(RS2_id), .USE1_id(USE1_id), .USE2_id(USE2_id),
        .RD_id(RD_id), .RW_id(RW_id), .MD_id(MD_id), .MP_ex(MP_ex),
        .stall_if(s_stall_if), .flush_ifid(s_flush_ifid), .flush_idex(s_flush_idex),
        .FW0(s_FW0), .FW1(s_FW1), .FW00(s_FW00), .FW01(s_FW01), .FW02(s_FW02),
        .FW10(s_FW10), .FW11(s_FW11), .FW12(s_FW12),
        .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic producesReg(input slot_t s, input logic [4:0] r);
        return s.v && s.rw && (s.rd == r) && (r != 5'd0);
    endfunction

    // Returns {any, from EX, from MEM, from WB} for one source operand
    function automatic logic [3:0] modelForward(input logic useIt, input logic [4:0] r);
        logic [3:0] res;
        res = 4'b0000;
        if (useIt) begin
            for (int k = 0; k < 3; k++) begin
                if (res == 4'b0000 && producesReg(hist[k], r)) res = 4'b1000 | (4'b0100 >> k);
            end
        end
        return res;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        nVectors++;
        if (got !== want) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input logic rst, input logic v,
                                 input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2,
                                 input logic [4:0] rd, input logic rw,
                                 input logic md, input logic mp);
        exp_t  e;
        exp_t  got;
        logic  lu;
        slot_t newSlot;
        @(posedge clk);
        #1;
        reset = rst; valid_id = v; RS1_id = rs1; USE1_id = u1; RS2_id = rs2; USE2_id = u2;
        RD_id = rd; RW_id = rw; MD_id = md; MP_ex = mp;

        lu = v && hist[0].md && ((u1 && producesReg(hist[0], rs1)) || (u2 && producesReg(hist[0], rs2)));
        e.fw = 8'h00;
        if (rst || mp)   e.ctl = 3'b011;
        else if (lu)     e.ctl = 3'b101;
        else begin
            e.ctl = 3'b000;
            e.fw  = {modelForward(v && u1, rs1), modelForward(v && u2, rs2)};
        end
        e.sc  = 16'(mStall);
        e.fc  = 16'(mFlush);
        e.ssc = 4'(mStallSat);
        e.sfc = 4'(mFlushSat);
        sb.push_back(e);

        if (rst) begin
            for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 5'd0, 1'b0, 1'b0};
            mStall = 0; mFlush = 0; mStallSat = 0; mFlushSat = 0;
        end else begin
            newSlot = e.ctl[0] ? '{1'b0, 5'd0, 1'b0, 1'b0} : '{v, rd, rw, md};
            hist[2] = hist[1];
            hist[1] = hist[0];
            hist[0] = newSlot;
            if (e.ctl[2]) begin
                if (mStall < 65535) mStall++;
                if (mStallSat < 15) mStallSat++;
            end
            if (mp) begin
                if (mFlush < 65535) mFlush++;
                if (mFlushSat < 15) mFlushSat++;
            end
        end

        @(negedge clk);
        got = sb.pop_front();
        checkOutput("ctl", {29'd0, stall_if, flush_ifid, flush_idex}, {29'd0, got.ctl});
        checkOutput("fw", {24'd0, FW0, FW00, FW01, FW02, FW1, FW10, FW11, FW12}, {24'd0, got.fw});
        checkOutput("stall_cnt", {16'd0, stall_cnt}, {16'd0, got.sc});
        checkOutput("flush_cnt", {16'd0, flush_cnt}, {16'd0, got.fc});
        checkOutput("sat_stall_cnt", {28'd0, s_stall_cnt}, {28'd0, got.ssc});
        checkOutput("sat_flush_cnt", {28'd0, s_flush_cnt}, {28'd0, got.sfc});
    endtask

    // Directed scenarios, a short random run, then saturation of the narrow counters
    initial begin
        reset = 1'b1; valid_id = 1'b0; RS1_id = 5'd0; RS2_id = 5'd0; USE1_id = 1'b0;
        USE2_id = 1'b0; RD_id = 5'd0; RW_id = 1'b0; MD_id = 1'b0; MP_ex = 1'b0;
        for (int k = 0; k < 3; k++) hist[k] = '{1'b0, 5'd0, 1'b0, 1'b0};
        mStall = 0; mFlush = 0; mStallSat = 0; mFlushSat = 0;

        //             rst  v  rs1 u1 rs2 u2 rd rw md mp
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        // ALU chain at distance 1
        applyStimulus(0, 1, 0, 0, 0, 0, 5, 1, 0, 0);
        applyStimulus(0, 1, 5, 1, 0, 0, 6, 1, 0, 0);

        // x7 in WB and MEM, consumer reads rs2
        applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 7, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 9, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 7, 1, 11, 1, 0, 0);

        // Load-use on rs1, then the retried instruction forwards from MEM
        applyStimulus(0, 1, 0, 0, 0, 0, 3, 1, 1, 0);
        applyStimulus(0, 1, 3, 1, 0, 0, 12, 1, 0, 0);
        applyStimulus(0, 1, 3, 1, 0, 0, 12, 1, 0, 0);

        // Load to x0, store with rd field 4
        applyStimulus(0, 1, 0, 0, 0, 0, 0, 1, 1, 0);
        applyStimulus(0, 1, 0, 1, 0, 1, 13, 1, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 4, 0, 0, 0);
        applyStimulus(0, 1, 4, 1, 4, 1, 14, 1, 0, 0);

        // Mispredict coinciding with load-use, then held for two cycles
        applyStimulus(0, 1, 0, 0, 0, 0, 8, 1, 1, 0);
        applyStimulus(0, 1, 0, 0, 8, 1, 15, 1, 0, 1);
        applyStimulus(0, 1, 8, 1, 0, 0, 16, 1, 0, 0);
        applyStimulus(0, 1, 8, 1, 8, 1, 17, 1, 0, 1);
        applyStimulus(0, 1, 8, 1, 0, 0, 18, 1, 0, 1);
        applyStimulus(0, 1, 17, 1, 8, 1, 0, 0, 0, 0);

        // Reset asserted in a stall cycle, then reads of the old load target
        applyStimulus(0, 1, 0, 0, 0, 0, 3, 1, 1, 0);
        applyStimulus(1, 1, 3, 1, 0, 0, 19, 1, 0, 0);
        applyStimulus(0, 1, 3, 1, 3, 1, 20, 1, 0, 0);

        // Random traffic over a small register set
        for (int i = 0; i < 40; i++) begin
            applyStimulus(0, 1'($urandom_range(0, 3) != 0),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                          5'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));
        end

        // Self-dependent loads: alternating stall and MEM forward, 20 stalls
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0, 0, 10, 1, 1, 0);
        for (int i = 0; i < 40; i++) applyStimulus(0, 1, 10, 1, 0, 0, 10, 1, 1, 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        checkOutput("final_stall_cnt", {16'd0, stall_cnt}, 32'd20);
        checkOutput("final_sat_stall_cnt", {28'd0, s_stall_cnt}, 32'd15);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
